// File: rtl/ysyx_23060072_regfile_sb.sv
// RV32E register file (x1..x15) with same-cycle writeback bypass and a
// per-register pending-write scoreboard that raises a decode stall on RAW
// hazards or a saturated counter. Addresses with bit 4 set are illegal:
// writes are dropped, reads return 0, and they are never busy.
module ysyx_23060072_regfile_sb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_flag_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic        rs1_used_i,
    input  logic        rs2_used_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    input  logic        issue_valid_i,
    input  logic        issue_wen_i,
    input  logic [4:0]  issue_rd_i,
    input  logic        flush_i,
    output logic        hazard_o,
    output logic        sb_err_o
);

    typedef logic [1:0] cnt_t;

    // Entry 0 exists only to keep indexing uniform; it is never written and
    // stays 0, so x0 and its counter read as zero by construction.
    logic [31:0] regs_q [16];
    cnt_t        cnt_q  [16];
    cnt_t        cnt_d  [16];
    logic        err_q;
    logic        err_d;

    logic wb_legal;
    logic rs1_legal;
    logic rs2_legal;
    logic rd_legal;
    logic rs1_wb_hit;
    logic rs2_wb_hit;
    logic rs1_busy;
    logic rs2_busy;
    logic rd_full;
    logic issue_fire;

    // "Legal" means bit 4 clear and not x0.
    assign wb_legal   = wb_flag_i & ~wb_addr_i[4] & (wb_addr_i[3:0] != 4'd0);
    assign rs1_legal  = ~rs1_addr_i[4] & (rs1_addr_i[3:0] != 4'd0);
    assign rs2_legal  = ~rs2_addr_i[4] & (rs2_addr_i[3:0] != 4'd0);
    assign rd_legal   = ~issue_rd_i[4] & (issue_rd_i[3:0] != 4'd0);
    assign rs1_wb_hit = wb_legal & (wb_addr_i == rs1_addr_i);
    assign rs2_wb_hit = wb_legal & (wb_addr_i == rs2_addr_i);

    // Combinational read ports with writeback bypass.
    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        if (rs1_legal) rs1_data_o = rs1_wb_hit ? wb_data_i : regs_q[rs1_addr_i[3:0]];
        if (rs2_legal) rs2_data_o = rs2_wb_hit ? wb_data_i : regs_q[rs2_addr_i[3:0]];
    end

    // Busy: more than one write outstanding, or exactly one not retiring now.
    always_comb begin
        rs1_busy = rs1_legal & ((cnt_q[rs1_addr_i[3:0]] > 2'd1) |
                                ((cnt_q[rs1_addr_i[3:0]] == 2'd1) & ~rs1_wb_hit));
        rs2_busy = rs2_legal & ((cnt_q[rs2_addr_i[3:0]] > 2'd1) |
                                ((cnt_q[rs2_addr_i[3:0]] == 2'd1) & ~rs2_wb_hit));
        rd_full  = issue_wen_i & rd_legal & (cnt_q[issue_rd_i[3:0]] == 2'd3);
    end

    assign hazard_o   = (rs1_used_i & rs1_busy) | (rs2_used_i & rs2_busy) | rd_full;
    assign issue_fire = issue_valid_i & issue_wen_i & rd_legal & ~hazard_o;
    assign sb_err_o   = err_q;

    // Scoreboard next state: saturating +1/-1 with error flag, flush wins.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        err_d = err_q;
        for (int i = 0; i < 16; i++) begin
            cnt_d[i] = cnt_q[i];
            if (issue_fire && (issue_rd_i[3:0] == 4'(i)) &&
                !(wb_legal && (wb_addr_i[3:0] == 4'(i)))) begin
                if (cnt_q[i] == 2'd3) err_d = 1'b1;
                else                  cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (wb_legal && (wb_addr_i[3:0] == 4'(i)) &&
                         !(issue_fire && (issue_rd_i[3:0] == 4'(i)))) begin
                if (cnt_q[i] == 2'd0) err_d = 1'b1;
                else                  cnt_d[i] = cnt_q[i] - 2'd1;
            end
            if (flush_i) cnt_d[i] = '0;
        end
    end

    // Scoreboard and sticky error state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            err_q <= 1'b0;
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
        end else begin
            err_q <= err_d;
            for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Register array write port; writes land regardless of flush.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the array is reset on purpose: architectural state must read
        // 0 immediately on reset, which rules out a plain RAM macro here.
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= '0;
        end else if (wb_legal) begin
            regs_q[wb_addr_i[3:0]] <= wb_data_i;
        end
    end

endmodule

// File: tb/tb_ysyx_23060072_regfile_sb.sv
// Bench for ysyx_23060072_regfile_sb: directed vectors with literal checks,
// plus a behavioural model compared against the outputs every cycle.
module tb_ysyx_23060072_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wb_flag_i = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic [31:0] wb_data_i = '0;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic        rs1_used_i = 1'b0;
    logic        rs2_used_i = 1'b0;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        issue_valid_i = 1'b0;
    logic        issue_wen_i = 1'b0;
    logic [4:0]  issue_rd_i = '0;
    logic        flush_i = 1'b0;
    logic        hazard_o;
    logic        sb_err_o;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Model state: architectural registers, pending-write counts, error flag.
    logic [31:0] m_reg [16] = '{default: '0};
    int          m_cnt [16] = '{default: 0};
    bit          m_err = 1'b0;

    ysyx_23060072_regfile_sb dut (
        .clk(clk), .rst_n(rst_n),
        .wb_flag_i(wb_flag_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .issue_valid_i(issue_valid_i), .issue_wen_i(issue_wen_i), .issue_rd_i(issue_rd_i),
        .flush_i(flush_i), .hazard_o(hazard_o), .sb_err_o(sb_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [4:0] a);
        return (a != 5'd0) && (a < 5'd16);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (!legal(a)) return 32'h0;
        if (wb_flag_i && wb_addr_i == a) return wb_data_i;
        return m_reg[a[3:0]];
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        int c;
        if (!legal(a)) return 1'b0;
        c = m_cnt[a[3:0]];
        return (c > 1) || (c == 1 && !(wb_flag_i && wb_addr_i == a));
    endfunction

    function automatic bit m_hazard();
        bit full;
        full = issue_wen_i && legal(issue_rd_i) && (m_cnt[issue_rd_i[3:0]] == 3);
        return (rs1_used_i && m_busy(rs1_addr_i)) || (rs2_used_i && m_busy(rs2_addr_i)) || full;
    endfunction

    task automatic model_step();
        bit hz;
        int inc_r;
        int dec_r;
        int d;
        hz    = m_hazard();
        inc_r = (issue_valid_i && issue_wen_i && !hz && legal(issue_rd_i)) ? int'(issue_rd_i) : -1;
        dec_r = (wb_flag_i && legal(wb_addr_i)) ? int'(wb_addr_i) : -1;
        for (int r = 1; r < 16; r++) begin
            d = int'(r == inc_r) - int'(r == dec_r);
            if (d > 0) begin
                if (m_cnt[r] == 3) m_err = 1'b1; else m_cnt[r] = m_cnt[r] + 1;
            end else if (d < 0) begin
                if (m_cnt[r] == 0) m_err = 1'b1; else m_cnt[r] = m_cnt[r] - 1;
            end
        end
        if (flush_i) for (int r = 0; r < 16; r++) m_cnt[r] = 0;
        if (dec_r > 0) m_reg[dec_r] = wb_data_i;
    endtask

    // Model update, mirroring the asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 16; r++) begin
                m_reg[r] = '0;
                m_cnt[r] = 0;
            end
            m_err = 1'b0;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_rs1_data", rs1_data_o, m_read(rs1_addr_i));
            check("cmp_rs2_data", rs2_data_o, m_read(rs2_addr_i));
            check("cmp_hazard", {31'b0, hazard_o}, {31'b0, m_hazard()});
            check("cmp_sb_err", {31'b0, sb_err_o}, {31'b0, m_err});
        end
    end

    task automatic idle();
        wb_flag_i = 0; wb_addr_i = 0; wb_data_i = 0;
        rs1_addr_i = 0; rs2_addr_i = 0; rs1_used_i = 0; rs2_used_i = 0;
        issue_valid_i = 0; issue_wen_i = 0; issue_rd_i = 0; flush_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid_i = 1; issue_wen_i = 1; issue_rd_i = rd;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_flag_i = 1; wb_addr_i = a; wb_data_i = d;
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        tick(); tick();
        rs1_addr_i = 5; #1;
        check("reset_rs1", rs1_data_o, 32'h0);
        check("reset_hazard", {31'b0, hazard_o}, 32'h0);
        check("reset_err", {31'b0, sb_err_o}, 32'h0);
        idle();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Write x5 then read it back
        tick(); issue(5);
        tick(); idle(); wb(5, 32'hDEADBEEF);
        tick(); idle(); rs1_addr_i = 5; rs1_used_i = 1; #1;
        check("x5_read", rs1_data_o, 32'hDEADBEEF);
        check("x5_not_busy", {31'b0, hazard_o}, 32'h0);

        // Same-cycle bypass on rs2, retiring the only pending write
        tick(); idle(); issue(7);
        tick(); idle(); wb(7, 32'hA5A5A5A5); rs2_addr_i = 7; rs2_used_i = 1; #1;
        check("x7_bypass", rs2_data_o, 32'hA5A5A5A5);
        check("x7_bypass_nohaz", {31'b0, hazard_o}, 32'h0);

        // Illegal address aliasing x5 and a write to x0 are both dropped
        tick(); idle(); wb(5'h15, 32'h77);
        tick(); idle(); wb(0, 32'h1234);
        tick(); idle(); rs1_addr_i = 5; rs2_addr_i = 5'h15; #1;
        check("illegal_no_alias", rs1_data_o, 32'hDEADBEEF);
        check("illegal_read_zero", rs2_data_o, 32'h0);
        rs1_addr_i = 0; #1;
        check("x0_read_zero", rs1_data_o, 32'h0);
        check("err_clean", {31'b0, sb_err_o}, 32'h0);

        // RAW hazard on x3; issue attempted during stall is dropped
        tick(); idle(); issue(3);
        tick(); idle(); rs1_addr_i = 3; rs1_used_i = 1; issue(8); #1;
        check("x3_hazard", {31'b0, hazard_o}, 32'h1);
        tick(); idle(); rs1_addr_i = 3; rs1_used_i = 1; wb(3, 32'h33); #1;
        check("x3_wb_nohaz", {31'b0, hazard_o}, 32'h0);
        check("x3_wb_bypass", rs1_data_o, 32'h33);
        tick(); idle(); rs2_addr_i = 8; rs2_used_i = 1; #1;
        check("x8_stalled_issue_ignored", {31'b0, hazard_o}, 32'h0);

        // Counter saturation on x4
        tick(); idle(); issue(4);
        tick(); tick();
        tick(); idle(); issue_wen_i = 1; issue_rd_i = 4; #1;
        check("x4_full_hazard", {31'b0, hazard_o}, 32'h1);
        issue_valid_i = 1;
        tick(); idle(); issue_wen_i = 1; issue_rd_i = 4; #1;
        check("x4_still_full", {31'b0, hazard_o}, 32'h1);
        idle(); wb(4, 32'h4);
        tick(); tick();
        tick(); idle(); rs1_addr_i = 4; rs1_used_i = 1; #1;
        check("x4_drained", {31'b0, hazard_o}, 32'h0);
        check("x4_drain_no_err", {31'b0, sb_err_o}, 32'h0);

        // Spurious writeback underflows and the error sticks
        wb(9, 32'h9);
        tick(); idle(); #1;
        check("x9_underflow_err", {31'b0, sb_err_o}, 32'h1);
        tick(); tick(); #1;
        check("err_sticky", {31'b0, sb_err_o}, 32'h1);

        // Flush clears pending state, overrides issue, keeps the write
        idle(); issue(6);
        tick(); idle(); rs1_addr_i = 6; rs1_used_i = 1; #1;
        check("x6_hazard", {31'b0, hazard_o}, 32'h1);
        idle(); flush_i = 1; issue(10); wb(11, 32'hBB);
        tick(); idle(); rs1_addr_i = 6; rs1_used_i = 1; rs2_addr_i = 10; rs2_used_i = 1; #1;
        check("flush_clears_x6", {31'b0, hazard_o}, 32'h0);
        rs2_addr_i = 11; #1;
        check("flush_keeps_write", rs2_data_o, 32'hBB);

        // Mid-cycle asynchronous reset with x2 pending
        tick(); idle(); issue(2);
        tick(); idle(); issue(2); wb(2, 32'h55);
        tick(); idle(); rs1_addr_i = 2; rs1_used_i = 1; #1;
        check("x2_pending_hazard", {31'b0, hazard_o}, 32'h1);
        check("x2_value", rs1_data_o, 32'h55);
        rst_n = 1'b0; #1;
        check("async_rst_x2", rs1_data_o, 32'h0);
        check("async_rst_hazard", {31'b0, hazard_o}, 32'h0);
        check("async_rst_err", {31'b0, sb_err_o}, 32'h0);
        wb(12, 32'h00C0FFEE); rs2_addr_i = 12; #1;
        check("rst_bypass", rs2_data_o, 32'h00C0FFEE);
        tick(); idle(); rst_n = 1'b1;
        rs1_addr_i = 2; rs1_used_i = 1; #1;
        check("post_rst_x2", rs1_data_o, 32'h0);
        check("post_rst_hazard", {31'b0, hazard_o}, 32'h0);
        tick(); idle(); issue(2);
        tick(); idle(); rs1_addr_i = 2; rs1_used_i = 1; #1;
        check("post_rst_fresh_issue", {31'b0, hazard_o}, 32'h1);

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
